mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 160 ++++++++++++++++
 tb/tb_mdu_iter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Iterative 32-bit unsigned multiply / divide unit with a
//             register-file write-back port. One shift-add (MUL/MULHU) or
//             restoring-division (DIVU/REMU) step is performed per cycle.
//             The fixed latency is 33 cycles from acceptance to the write
//             pulse, and the unit is busy for 34 cycles.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, op, src1,
//             src2, dest          - request (sampled only when idle)
//             busy                - operation in flight (CALC or WB)
//             wen, waddr, wdata   - one-cycle register-file write in WB
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [4:0]  dest,
    output logic        busy,
    output logic        wen,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        setup_q, setup_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  dest_q, dest_d;
    // Shared 64-bit working register.
    //   multiply: {partial high product, remaining multiplier bits / low product}
    //   divide  : {partial remainder, remaining dividend bits / quotient bits}
    logic [63:0] acc_q, acc_d;

    logic        w_is_div;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_part;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [31:0] w_result;

    assign w_is_div = op_q[1];

    // One step of each algorithm, computed from the current working register.
    always_comb begin
        // Shift-add: add the multiplicand to the high half if the current
        // multiplier LSB is set, then shift the whole 65-bit value right.
        w_mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        w_mul_next = {w_mul_sum, acc_q[31:1]};

        // Restoring division: shift next dividend bit into the remainder and
        // subtract the divisor when it fits. A zero divisor always "fits",
        // which yields an all-ones quotient and the dividend as remainder.
        w_div_part = {acc_q[63:32], acc_q[31]};
        w_div_ge   = (w_div_part >= {1'b0, b_q});
        // The true difference is below the divisor, so 32 bits suffice.
        w_div_diff = w_div_part[31:0] - b_q;
        w_div_next = w_div_ge ? {w_div_diff, acc_q[30:0], 1'b1}
                              : {w_div_part[31:0], acc_q[30:0], 1'b0};

        // MUL/DIVU take the low half, MULHU/REMU the high half.
        w_result   = op_q[0] ? acc_q[63:32] : acc_q[31:0];
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        setup_d = setup_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        dest_d  = dest_q;
        acc_d   = acc_q;
        busy    = 1'b0;
        wen     = 1'b0;
        waddr   = 5'd0;
        wdata   = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = op;
                    dest_d  = dest;
                    cnt_d   = 5'd0;
                    setup_d = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (setup_q) begin
                    // First CALC cycle seeds the working register from the
                    // latched operands; the 32 iterations follow.
                    setup_d = 1'b0;
                    acc_d   = w_is_div ? {32'd0, a_q} : {32'd0, b_q};
                end else begin
                    acc_d = w_is_div ? w_div_next : w_mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == C_LAST_ITER) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                busy    = 1'b1;
                wen     = (dest_q != 5'd0);
                waddr   = dest_q;
                wdata   = w_result;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            setup_q <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            dest_q  <= 5'd0;
            acc_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            setup_q <= setup_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Self-checking bench for mdu_iter. Stimulus pushes expected
//             write-backs (address, data, cycle) into a queue; a monitor pops
//             and compares on every write pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        busy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          when;
    } exp_t;

    exp_t exp_q[$];

    mdu_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src1  (src1),
        .src2  (src2),
        .dest  (dest),
        .busy  (busy),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every write pulse must match the head of the queue; when idle
    // all outputs must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (wen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wen", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("waddr", {59'd0, waddr}, {59'd0, e.addr});
                    check("wdata", {32'd0, wdata}, {32'd0, e.data});
                    check("wen_cycle", 64'(cyc), 64'(e.when));
                end
            end
            if (!busy) begin
                check("idle_outs", {27'd0, wen, waddr, wdata}, 64'd0);
            end
        end
    end

    // mode: 0 quiet, 1 random disturbance while busy, 2 start 9*9 at busy
    // cycle 10 and in the WB cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input int mode);
        int n;
        exp_t e;
        @(negedge clk);
        op = o; src1 = a; src2 = b; dest = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e.addr = d;
        e.data = model(o, a, b);
        e.when = cyc + 33;
        if (d != 5'd0) exp_q.push_back(e);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom);
                src1  = $urandom;
                src2  = $urandom;
                dest  = 5'($urandom);
            end else if (mode == 2) begin
                start = (n == 10 || n == 34);
                op = 2'b00; src1 = 32'd9; src2 = 32'd9; dest = 5'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 64'(n), 64'd34);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; src1 = 32'd0; src2 = 32'd0; dest = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_wen",   {63'd0, wen}, 64'd0);
        check("rst_waddr", {59'd0, waddr}, 64'd0);
        check("rst_wdata", {32'd0, wdata}, 64'd0);

        // Directed cases.
        issue(2'b00, 32'd7, 32'd6, 5'd3, 0);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
        issue(2'b10, 32'd100, 32'd7, 5'd9, 0);
        issue(2'b11, 32'd100, 32'd7, 5'd9, 0);
        issue(2'b10, 32'd5, 32'd0, 5'd9, 0);
        issue(2'b11, 32'd5, 32'd0, 5'd9, 0);
        issue(2'b00, 32'd3, 32'd4, 5'd1, 2);
        issue(2'b00, 32'd2, 32'd3, 5'd0, 0);

        // Abort by reset mid-calculation: no write may follow.
        @(negedge clk);
        op = 2'b10; src1 = 32'd1000; src2 = 32'd3; dest = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        issue(2'b10, 32'd1000, 32'd3, 5'd7, 0);

        // Randomized operations, with input disturbance while busy.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = b >> $urandom_range(0, 31);
                2: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(2'($urandom), a, b, 5'($urandom), int'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
